fp_div_round: RTL and testbench
===============================

Name: fp_div_round

Overview:
- Normalize/round/pack stage directly downstream of the double-precision mantissa divider in the FP division path.
- Consumes the raw quotient, remainder-nonzero sticky, sign, pre-computed exponent and special-case flags.
- Produces a packed IEEE-754 binary64 result using round-to-nearest-even.
- Two-stage valid/ready pipeline, so the combinational divider output can be registered and back-pressured.

Parameters:
- QW, 55, quotient width; leading one is at bit QW-1 or QW-2; must be at least 55.
- EW, 13, signed two's-complement width of in_exp.

Ports:
- in_clk  input  1  clock; all state on rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operand valid.
- out_ready  output  1  this block can accept an operand this cycle.
- in_sign  input  1  result sign (sign_a XOR sign_b).
- in_exp  input  EW  biased exponent: value = (q/2^(QW-1)) * 2^(in_exp-1023).
- in_quotient  input  QW  raw mantissa quotient.
- in_rem_nz  input  1  divider remainder nonzero (sticky).
- in_is_nan, in_is_inf, in_is_zero  input  1 each  special-case flags from unpack.
- out_valid  output  1  result valid.
- in_ready  input  1  downstream accepts the result.
- out_result  output  64  packed binary64 result.

Behaviour:
- Reset (asynchronous, in_rst=1): both stage valids clear; out_valid=0; out_result=0; out_ready=1 in the first cycle after reset release.
- Handshake:
  - Transfer in: in_valid & out_ready. Transfer out: out_valid & in_ready.
  - Stage-2 register enable: s2_en = !s2_valid | in_ready.
  - Stage-1 register enable: s1_en = !s1_valid | s2_en; out_ready = s1_en.
  - Latency is 2 cycles from accept to out_valid with no stall; throughput is 1 per cycle.
  - While out_valid=1 and in_ready=0, out_result holds stable.
  - Data order is preserved; no drops or duplicates under any stall pattern.
- Stage 1, normalize (registered):
  - If q[QW-1]=0: shift q left by 1, e = in_exp-1. Otherwise e = in_exp.
  - If e <= 0 (subnormal): shift significand right by 1-e, OR all shifted-out bits into sticky, set e=0. Shift amounts of QW+1 or more collapse everything into sticky.
  - sticky |= in_rem_nz.
  - If e >= 2047: set overflow.
  - Register sign, e, significand, sticky, overflow and special flags.
- Stage 2, round/pack (registered):
  - frac = sig[QW-2:QW-53]; guard = sig[QW-54]; rest = |sig[QW-55:0] | sticky.
  - Increment when guard & (rest | frac[0]).
  - The 53-bit sum {hidden,frac}+inc carries into exponent naturally: subnormal→min normal gives exp 1; 1.111…→2.0 gives exp+1.
  - Exponent reaching 2047 after rounding, or the overflow flag set: output ±Inf (exp 0x7FF, frac 0).
  - Subnormal input to stage 2 has hidden bit 0 and exponent field 0.
- Specials, priority nan > inf > zero:
  - NaN → 0x7FF8000000000000.
  - Inf → {sign, 0x7FF, 52'b0}.
  - Zero → {sign, 63'b0}.
  - Specials bypass rounding but travel the same pipeline and latency.
- Reset asserted mid-operation: all in-flight results are discarded immediately, with no output pulse.

Optional Feature:
- Macro FP_DIV_ROUND_FLAGS_EN.
- When defined: adds port out_flags output 5 = {invalid, divzero, overflow, underflow, inexact}, registered alongside out_result and reset to 0.
  - inexact: guard | rest is nonzero, or overflow occurred.
  - underflow: result tiny (e <= 0 before rounding) and inexact.
  - overflow: Inf produced from a finite operand.
  - invalid: in_is_nan.
  - divzero: in_is_inf & in_rem_nz. Upstream drives in_rem_nz=1 with in_is_inf to mark x/0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- 1.0/1.0: q=1<<54, exp=1023, rem_nz=0 → out_valid 2 cycles after accept, out_result=0x3FF0000000000000.
- Tie to even:
  - q=(1<<54)|(1<<1), exp=1023, rem_nz=0 → 0x3FF0000000000000, no increment.
  - Same q with rem_nz=1 → 0x3FF0000000000001.
- Overflow:
  - exp=2047, q=1<<54 → 0x7FF0000000000000.
  - exp=2046, q=all ones, sign=1 → 0xFFF0000000000000 after rounding carry.
- Subnormal:
  - exp=0, q=1<<54 → 0x0008000000000000.
  - exp=-60, q=1<<54 → 0x0000000000000000, with inexact=1 and underflow=1 when flags are enabled.
- Backpressure: stream 5 operands with in_ready held 0 for 4 cycles → out_ready drops after 2 accepts, all 5 results emerge in order with none lost, out_result stable while stalled.
- Reset mid-flight: assert in_rst with both stages valid → out_valid=0 immediately; after release the first new operand emerges with 2-cycle latency.

Source files
------------

// File: rtl/fp_div_round.sv
// fp_div_round: normalize, round-to-nearest-even and pack the binary64 divider quotient.
// Defining FP_DIV_ROUND_FLAGS_EN adds the registered out_flags exception port.
module fp_div_round #(
    parameter int QW = 55,
    parameter int EW = 13
) (
    input  logic          in_clk,
    input  logic          in_rst,
    input  logic          in_valid,
    output logic          out_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [QW-1:0] in_quotient,
    input  logic          in_rem_nz,
    input  logic          in_is_nan,
    input  logic          in_is_inf,
    input  logic          in_is_zero,
    output logic          out_valid,
    input  logic          in_ready,
    output logic [63:0]   out_result
`ifdef FP_DIV_ROUND_FLAGS_EN
    ,
    output logic [4:0]    out_flags
`endif
);
    localparam int XW = EW + 1;
    localparam logic [XW-1:0] ONE_X   = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0] ZERO_X  = {XW{1'b0}};
    localparam logic [XW-1:0] QW_X    = XW'(QW);
    localparam logic [EW-1:0] EMAX_X  = {{(EW-11){1'b0}}, 11'h7FF};

    logic            w_s1_en;
    logic            w_s2_en;
    logic            r_s1_valid;
    logic            r_s2_valid;

    logic [XW-1:0]   w_exp_x;
    logic [XW-1:0]   w_e_norm;
    logic [QW-1:0]   w_sig_norm;
    logic            w_tiny;
    logic [XW-1:0]   w_shamt;
    logic [2*QW-1:0] w_wide;
    logic [QW-1:0]   w_s1_sig;
    logic            w_s1_sticky;
    logic [10:0]     w_s1_exp;
    logic            w_s1_ovf;

    logic            r_s1_sign;
    logic [10:0]     r_s1_exp;
    logic [QW-1:0]   r_s1_sig;
    logic            r_s1_sticky;
    logic            r_s1_ovf;
    logic            r_s1_nan;
    logic            r_s1_inf;
    logic            r_s1_zero;

    logic [51:0]     w_frac;
    logic            w_guard;
    logic            w_rest;
    logic            w_inc;
    logic [62:0]     w_sum;
    logic            w_to_inf;
    logic [63:0]     w_result;
    logic [63:0]     r_result;

    assign w_s2_en   = !r_s2_valid | in_ready;
    assign w_s1_en   = !r_s1_valid | w_s2_en;
    assign out_ready = w_s1_en;
    assign out_valid = r_s2_valid;
    assign out_result = r_result;

    // Stage 1 combinational: normalize, denormalize tiny results, detect overflow
    always_comb begin
        w_exp_x = {in_exp[EW-1], in_exp};
        if (in_quotient[QW-1]) begin
            w_sig_norm = in_quotient;
            w_e_norm   = w_exp_x;
        end else begin
            w_sig_norm = {in_quotient[QW-2:0], 1'b0};
            w_e_norm   = w_exp_x - ONE_X;
        end
        w_tiny  = w_e_norm[XW-1] | (w_e_norm == ZERO_X);
        w_shamt = ONE_X - w_e_norm;
        w_wide  = {w_sig_norm, {QW{1'b0}}} >> w_shamt;
        if (w_tiny) begin
            w_s1_exp = 11'd0;
            w_s1_ovf = 1'b0;
            // Shifts beyond the whole significand leave only sticky.
            if (w_shamt > QW_X) begin
                w_s1_sig    = {QW{1'b0}};
                w_s1_sticky = |w_sig_norm;
            end else begin
                w_s1_sig    = w_wide[2*QW-1:QW];
                w_s1_sticky = |w_wide[QW-1:0];
            end
        end else begin
            w_s1_exp    = w_e_norm[10:0];
            w_s1_ovf    = (w_e_norm[XW-2:0] >= EMAX_X);
            w_s1_sig    = w_sig_norm;
            w_s1_sticky = 1'b0;
        end
        w_s1_sticky = w_s1_sticky | in_rem_nz;
    end

    // Stage 1 pipeline register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_exp    <= 11'd0;
            r_s1_sig    <= {QW{1'b0}};
            r_s1_sticky <= 1'b0;
            r_s1_ovf    <= 1'b0;
            r_s1_nan    <= 1'b0;
            r_s1_inf    <= 1'b0;
            r_s1_zero   <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid  <= in_valid;
            r_s1_sign   <= in_sign;
            r_s1_exp    <= w_s1_exp;
            r_s1_sig    <= w_s1_sig;
            r_s1_sticky <= w_s1_sticky;
            r_s1_ovf    <= w_s1_ovf;
            r_s1_nan    <= in_is_nan;
            r_s1_inf    <= in_is_inf;
            r_s1_zero   <= in_is_zero;
        end
    end

    // Stage 2 combinational: RNE increment, carry into exponent, special-case pack
    always_comb begin
        w_frac   = r_s1_sig[QW-2:QW-53];
        w_guard  = r_s1_sig[QW-54];
        w_rest   = (|r_s1_sig[QW-55:0]) | r_s1_sticky;
        w_inc    = w_guard & (w_rest | w_frac[0]);
        w_sum    = {r_s1_exp, w_frac} + {62'd0, w_inc};
        w_to_inf = r_s1_ovf | (w_sum[62:52] == 11'h7FF);
        if (r_s1_nan) begin
            w_result = 64'h7FF8_0000_0000_0000;
        end else if (r_s1_inf) begin
            w_result = {r_s1_sign, 11'h7FF, 52'd0};
        end else if (r_s1_zero) begin
            w_result = {r_s1_sign, 63'd0};
        end else if (w_to_inf) begin
            w_result = {r_s1_sign, 11'h7FF, 52'd0};
        end else begin
            w_result = {r_s1_sign, w_sum};
        end
    end

    // Stage 2 output register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_s2_valid <= 1'b0;
            r_result   <= 64'd0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            r_result   <= w_result;
        end
    end

`ifdef FP_DIV_ROUND_FLAGS_EN
    logic       r_s1_tiny;
    logic       r_s1_divz;
    logic       w_inexact;
    logic [4:0] w_flags;
    logic [4:0] r_flags;

    // Stage 1 exception context
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_s1_tiny <= 1'b0;
            r_s1_divz <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_tiny <= w_tiny;
            r_s1_divz <= in_is_inf & in_rem_nz;
        end
    end

    // Flags: {invalid, divzero, overflow, underflow, inexact}; specials never round
    always_comb begin
        w_inexact = w_guard | w_rest | w_to_inf;
        if (r_s1_nan | r_s1_inf | r_s1_zero) begin
            w_flags = {r_s1_nan, r_s1_divz, 3'b000};
        end else begin
            w_flags = {2'b00, w_to_inf, r_s1_tiny & w_inexact, w_inexact};
        end
    end

    // Flags register, aligned with out_result
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_flags <= 5'd0;
        end else if (w_s2_en) begin
            r_flags <= w_flags;
        end
    end

    assign out_flags = r_flags;
`endif

endmodule

// File: tb/tb_fp_div_round.sv
// Directed self-checking bench for fp_div_round (flags checked when FP_DIV_ROUND_FLAGS_EN is defined).
module tb_fp_div_round;
    localparam logic [54:0] Q1 = {1'b1, 54'd0};

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_valid;
    logic        out_ready;
    logic        in_sign;
    logic [12:0] in_exp;
    logic [54:0] in_quotient;
    logic        in_rem_nz;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic        out_valid;
    logic        in_ready;
    logic [63:0] out_result;
`ifdef FP_DIV_ROUND_FLAGS_EN
    logic [4:0]  out_flags;
`endif

    int errors = 0;
    int checks = 0;

    fp_div_round #(.QW(55), .EW(13)) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_quotient (in_quotient),
        .in_rem_nz   (in_rem_nz),
        .in_is_nan   (in_is_nan),
        .in_is_inf   (in_is_inf),
        .in_is_zero  (in_is_zero),
        .out_valid   (out_valid),
        .in_ready    (in_ready),
        .out_result  (out_result)
`ifdef FP_DIV_ROUND_FLAGS_EN
        ,
        .out_flags   (out_flags)
`endif
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic s, input logic [12:0] e, input logic [54:0] q,
                         input logic rnz, input logic nan, input logic inf, input logic zero);
        in_sign     = s;
        in_exp      = e;
        in_quotient = q;
        in_rem_nz   = rnz;
        in_is_nan   = nan;
        in_is_inf   = inf;
        in_is_zero  = zero;
    endtask

    task automatic run_one(input string tag, input logic s, input logic [12:0] e, input logic [54:0] q,
                           input logic rnz, input logic nan, input logic inf, input logic zero,
                           input logic [63:0] exp_res);
        drive(s, e, q, rnz, nan, inf, zero);
        in_valid = 1'b1;
        in_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, {63'd0, out_ready}, 64'd1);
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(posedge in_clk); #1;
        check({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_res"}, out_result, exp_res);
    endtask

    initial begin
        int nacc;
        int nout;
        logic [63:0] held;
        logic [63:0] exp_bp;

        in_rst   = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        drive(1'b0, 13'd0, 55'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge in_clk);
        #1;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", out_result, 64'd0);
        in_rst = 1'b0;
        #1;
        check("rst_ready", {63'd0, out_ready}, 64'd1);

        run_one("one", 1'b0, 13'd1023, Q1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0000);
`ifdef FP_DIV_ROUND_FLAGS_EN
        check("one_flags", {59'd0, out_flags}, 64'h00);
`endif
        run_one("tie_even", 1'b0, 13'd1023, Q1 | 55'd2, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0000);
        run_one("tie_sticky", 1'b0, 13'd1023, Q1 | 55'd2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0001);
        run_one("rnd_up", 1'b0, 13'd1023, Q1 | 55'd3, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0001);
        run_one("tie_odd", 1'b0, 13'd1023, Q1 | 55'd6, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3FF0_0000_0000_0002);
        run_one("norm_shift", 1'b0, 13'd1025, {2'b01, 53'd0}, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4000_0000_0000_0000);
        run_one("ovf_exp", 1'b0, 13'd2047, Q1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7FF0_0000_0000_0000);
`ifdef FP_DIV_ROUND_FLAGS_EN
        check("ovf_exp_flags", {59'd0, out_flags}, 64'h05);
`endif
        run_one("ovf_rnd", 1'b1, 13'd2046, {55{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFF0_0000_0000_0000);
`ifdef FP_DIV_ROUND_FLAGS_EN
        check("ovf_rnd_flags", {59'd0, out_flags}, 64'h05);
`endif
        run_one("subn", 1'b0, 13'd0, Q1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0008_0000_0000_0000);
`ifdef FP_DIV_ROUND_FLAGS_EN
        check("subn_flags", {59'd0, out_flags}, 64'h00);
`endif
        run_one("subn_to_min", 1'b0, 13'd0, {55{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0010_0000_0000_0000);
`ifdef FP_DIV_ROUND_FLAGS_EN
        check("subn_to_min_flags", {59'd0, out_flags}, 64'h03);
`endif
        run_one("deep_subn", 1'b0, -13'sd60, Q1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0000);
`ifdef FP_DIV_ROUND_FLAGS_EN
        check("deep_subn_flags", {59'd0, out_flags}, 64'h03);
`endif
        run_one("nan", 1'b1, 13'd1023, Q1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h7FF8_0000_0000_0000);
`ifdef FP_DIV_ROUND_FLAGS_EN
        check("nan_flags", {59'd0, out_flags}, 64'h10);
`endif
        run_one("inf", 1'b1, 13'd0, 55'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hFFF0_0000_0000_0000);
`ifdef FP_DIV_ROUND_FLAGS_EN
        check("inf_flags", {59'd0, out_flags}, 64'h08);
`endif
        run_one("zero", 1'b1, 13'd0, 55'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000);

        // Drain, then stream 5 operands with downstream stalled for the first 4 cycles
        in_ready = 1'b1;
        @(posedge in_clk); #1;
        nacc = 0;
        nout = 0;
        held = 64'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_ready = (cyc >= 4);
            in_valid = (nacc < 5);
            drive(1'b0, 13'd1023 + 13'(nacc), Q1, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            if (cyc == 2) begin
                check("bp_ready_drop", {63'd0, out_ready}, 64'd0);
                check("bp_accepts", 64'(nacc), 64'd2);
                check("bp_stall_vld", {63'd0, out_valid}, 64'd1);
                held = out_result;
            end
            if (cyc == 3) begin
                check("bp_hold", out_result, held);
                check("bp_hold_vld", {63'd0, out_valid}, 64'd1);
            end
            if (out_valid && in_ready) begin
                exp_bp = {1'b0, 11'd1023 + 11'(nout), 52'd0};
                check("bp_out", out_result, exp_bp);
                nout++;
            end
            if (in_valid && out_ready) nacc++;
            @(posedge in_clk); #1;
        end
        in_valid = 1'b0;
        check("bp_out_count", 64'(nout), 64'd5);
        check("bp_in_count", 64'(nacc), 64'd5);

        // Fill both stages under stall, then reset mid-flight
        in_ready = 1'b0;
        in_valid = 1'b1;
        drive(1'b0, 13'd1000, Q1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge in_clk); #1;
        drive(1'b0, 13'd1001, Q1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        check("mid_full_vld", {63'd0, out_valid}, 64'd1);
        check("mid_full_rdy", {63'd0, out_ready}, 64'd0);
        in_rst = 1'b1;
        #1;
        check("mid_rst_vld", {63'd0, out_valid}, 64'd0);
        check("mid_rst_res", out_result, 64'd0);
        @(posedge in_clk); #1;
        in_rst   = 1'b0;
        in_ready = 1'b1;
        #1;
        check("post_rst_vld", {63'd0, out_valid}, 64'd0);
        run_one("post_rst", 1'b0, 13'd1030, Q1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4060_0000_0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
